id_ex_operand_stage: RTL

ID/EX pipeline register and operand-forwarding stage sitting directly upstream of the 32-bit ALU. It captures decoded operands and control each cycle, resolves EX/MEM and MEM/WB data hazards, and drives the ALU inputs A, B and ALUOperation. It also drives the write-back tag and store data to the next stage. It supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/id_ex_operand_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// Optional: define ID_EX_BUBBLE_CNT_EN to add the saturating BubbleCount output.
module id_ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      Valid_in,
    input  logic [DATA_WIDTH-1:0]     ReadData1_in,
    input  logic [DATA_WIDTH-1:0]     ReadData2_in,
    input  logic [DATA_WIDTH-1:0]     Immediate_in,
    input  logic                      ALUSrc_in,
    input  logic [3:0]                ALUOperation_in,
    input  logic                      RegWrite_in,
    input  logic [REG_ADDR_WIDTH-1:0] Rs_in,
    input  logic [REG_ADDR_WIDTH-1:0] Rt_in,
    input  logic [REG_ADDR_WIDTH-1:0] WriteRegister_in,
    input  logic                      EXMEM_RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] EXMEM_WriteRegister,
    input  logic [DATA_WIDTH-1:0]     EXMEM_ALUResult,
    input  logic                      MEMWB_RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] MEMWB_WriteRegister,
    input  logic [DATA_WIDTH-1:0]     MEMWB_WriteData,
    output logic [DATA_WIDTH-1:0]     A,
    output logic [DATA_WIDTH-1:0]     B,
    output logic [3:0]                ALUOperation,
    output logic [DATA_WIDTH-1:0]     StoreData,
    output logic                      RegWrite_out,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegister_out,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [31:0]               BubbleCount,
`endif
    output logic                      Valid_out
);

    logic                      valid_q, valid_d;
    logic                      regwrite_q, regwrite_d;
    logic                      alusrc_q, alusrc_d;
    logic [3:0]                aluop_q, aluop_d;
    logic [DATA_WIDTH-1:0]     rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
    logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;

    logic [DATA_WIDTH-1:0]     fwd_a;
    logic [DATA_WIDTH-1:0]     fwd_b;
    logic                      exmem_hit_a, exmem_hit_b, memwb_hit_a, memwb_hit_b;

    // Next-state selection: reset and flush clear, stall holds, otherwise load (bubble kills RegWrite)
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        wreg_d     = wreg_q;
        if (reset || Flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            alusrc_d   = 1'b0;
            aluop_d    = 4'b0000;
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            wreg_d     = '0;
        end else if (!Stall) begin
            valid_d    = Valid_in;
            regwrite_d = RegWrite_in & Valid_in;
            alusrc_d   = ALUSrc_in;
            aluop_d    = ALUOperation_in;
            rd1_d      = ReadData1_in;
            rd2_d      = ReadData2_in;
            imm_d      = Immediate_in;
            rs_d       = Rs_in;
            rt_d       = Rt_in;
            wreg_d     = WriteRegister_in;
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        valid_q    <= valid_d;
        regwrite_q <= regwrite_d;
        alusrc_q   <= alusrc_d;
        aluop_q    <= aluop_d;
        rd1_q      <= rd1_d;
        rd2_q      <= rd2_d;
        imm_q      <= imm_d;
        rs_q       <= rs_d;
        rt_q       <= rt_d;
        wreg_q     <= wreg_d;
    end

    // Hazard match: writer must be enabled and target a nonzero register equal to the source
    always_comb begin
        exmem_hit_a = EXMEM_RegWrite && (EXMEM_WriteRegister != '0) && (EXMEM_WriteRegister == rs_q);
        exmem_hit_b = EXMEM_RegWrite && (EXMEM_WriteRegister != '0) && (EXMEM_WriteRegister == rt_q);
        memwb_hit_a = MEMWB_RegWrite && (MEMWB_WriteRegister != '0) && (MEMWB_WriteRegister == rs_q);
        memwb_hit_b = MEMWB_RegWrite && (MEMWB_WriteRegister != '0) && (MEMWB_WriteRegister == rt_q);
    end

    // Operand muxes: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        if (exmem_hit_a)      fwd_a = EXMEM_ALUResult;
        else if (memwb_hit_a) fwd_a = MEMWB_WriteData;
        else                  fwd_a = rd1_q;

        if (exmem_hit_b)      fwd_b = EXMEM_ALUResult;
        else if (memwb_hit_b) fwd_b = MEMWB_WriteData;
        else                  fwd_b = rd2_q;
    end

    assign A                 = fwd_a;
    assign B                 = alusrc_q ? imm_q : fwd_b;
    assign StoreData         = fwd_b;
    assign ALUOperation      = aluop_q;
    assign RegWrite_out      = regwrite_q;
    assign WriteRegister_out = wreg_q;
    assign Valid_out         = valid_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Count edges that stalled or flushed, sticking at all-ones
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (reset)
            bubble_cnt_d = '0;
        else if ((Stall || Flush) && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    // Bubble counter register
    always_ff @(posedge clk) begin
        bubble_cnt_q <= bubble_cnt_d;
    end

    assign BubbleCount = bubble_cnt_q;
`endif

endmodule
